// File: rtl/shift_reg_univ.sv
`default_nettype none
// ============================================================================
// Module   : shift_reg_univ
// Purpose  : Universal register (hold/load/shift/rotate/invert) with serial
//            in/out and a frame counter for serialiser/deserialiser use.
// Revision : 1.0 - initial release
// ============================================================================
module shift_reg_univ #(
    parameter int                 WIDTH   = 8,
    parameter int                 CNT_W   = 4,
    parameter logic [WIDTH-1:0]   RST_VAL = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0]   SET_VAL = {WIDTH{1'b1}}
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              set,
    input  logic              en,
    input  logic [2:0]        mode,
    input  logic [WIDTH-1:0]  d,
    input  logic              sin,
    output logic [WIDTH-1:0]  q,
    output logic              sout_l,
    output logic              sout_r,
    output logic [CNT_W-1:0]  shift_cnt,
    output logic              frame_done
);

    localparam logic [2:0] c_MODE_HOLD = 3'b000;
    localparam logic [2:0] c_MODE_LOAD = 3'b001;
    localparam logic [2:0] c_MODE_SHL  = 3'b010;
    localparam logic [2:0] c_MODE_SHR  = 3'b011;
    localparam logic [2:0] c_MODE_ROL  = 3'b100;
    localparam logic [2:0] c_MODE_ROR  = 3'b101;
    localparam logic [2:0] c_MODE_INV  = 3'b110;

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] r_q;
    logic [CNT_W-1:0] r_cnt;
    logic             r_done;

    logic [WIDTH-1:0] w_q_next;
    logic             w_is_shift;
    logic             w_is_load;

    always_comb begin
        w_q_next   = r_q;
        w_is_shift = 1'b0;
        w_is_load  = 1'b0;
        case (mode)
            c_MODE_HOLD: w_q_next = r_q;
            c_MODE_LOAD: begin
                w_q_next  = d;
                w_is_load = 1'b1;
            end
            c_MODE_SHL: begin
                w_q_next   = {r_q[WIDTH-2:0], sin};
                w_is_shift = 1'b1;
            end
            c_MODE_SHR: begin
                w_q_next   = {sin, r_q[WIDTH-1:1]};
                w_is_shift = 1'b1;
            end
            c_MODE_ROL: begin
                w_q_next   = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
                w_is_shift = 1'b1;
            end
            c_MODE_ROR: begin
                w_q_next   = {r_q[0], r_q[WIDTH-1:1]};
                w_is_shift = 1'b1;
            end
            c_MODE_INV:  w_q_next = ~r_q;
            default:     w_q_next = r_q;
        endcase
    end

    // The WIDTH-th shift wraps the counter straight to 0 and raises the pulse,
    // so shift_cnt never shows WIDTH.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_q    <= RST_VAL;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else if (set) begin
            r_q    <= SET_VAL;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else if (en) begin
            r_q    <= w_q_next;
            r_done <= 1'b0;
            if (w_is_load) begin
                r_cnt <= '0;
            end else if (w_is_shift) begin
                if (r_cnt == c_CNT_LAST) begin
                    r_cnt  <= '0;
                    r_done <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + c_CNT_ONE;
                end
            end
        end else begin
            r_done <= 1'b0;
        end
    end

    assign q          = r_q;
    assign sout_l     = r_q[WIDTH-1];
    assign sout_r     = r_q[0];
    assign shift_cnt  = r_cnt;
    assign frame_done = r_done;

endmodule
`default_nettype wire
